rom_dl_sdram_ctrl: RTL and testbench

//  Parametrised ROM download controller: ioctl byte stream -> packed 16-bit SDRAM writes over toggle req/ack.

---
 rtl/rom_dl_sdram_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_rom_dl_sdram_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_sdram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rom_dl_sdram_ctrl
//  Purpose  : ROM download controller. Packs the data_io ioctl byte stream
//             into 16-bit SDRAM word writes, buffers them in a small FIFO and
//             issues them over a toggle req/ack write port. Each word carries
//             the index of the ROM region it belongs to. Produces the sticky
//             rom_loaded flag and a core reset that is held until the whole
//             download has drained into SDRAM.
//  Option   : `define DL_CHECKSUM_EN to build the 16-bit byte checksum
//             (o_dl_sum); without it o_dl_sum is tied to zero.
//  Ports    : i_clk_sys      system / SDRAM clock
//             i_reset        synchronous active-high reset
//             i_ioctl_*      data_io download stream (downl, wr, addr, dout)
//             i_user_reset   user reset request (status / button)
//             o_ram_addr     SDRAM word address (byte address [AW:1])
//             o_ram_din      write data {odd byte, even byte}
//             o_ram_ds       byte enables {odd, even}
//             o_ram_req      toggle request, i_ram_ack toggle acknowledge
//             o_ram_we       write outstanding or buffered
//             o_ram_region   region index of the current word
//             o_rom_loaded   sticky: a download completed and drained
//             o_core_reset   reset to the emulated core
//             o_dl_overflow  sticky: a word was lost to a full FIFO
//             o_dl_sum       byte checksum of the last download
//  Revision : 1.0  initial release
// ============================================================================
module rom_dl_sdram_ctrl #(
   parameter int                 AW         = 22,
   parameter int                 NREG       = 4,
   parameter logic [NREG*25-1:0] REG_END    = {25'h0040000, 25'h0010000,
                                               25'h0008000, 25'h0004000},
   parameter int                 FIFO_DEPTH = 4
) (
   input  logic          i_clk_sys,
   input  logic          i_reset,
   input  logic          i_ioctl_downl,
   input  logic          i_ioctl_wr,
   input  logic [24:0]   i_ioctl_addr,
   input  logic [7:0]    i_ioctl_dout,
   input  logic          i_user_reset,
   output logic [AW-1:0] o_ram_addr,
   output logic [15:0]   o_ram_din,
   output logic [1:0]    o_ram_ds,
   output logic          o_ram_req,
   input  logic          i_ram_ack,
   output logic          o_ram_we,
   output logic [2:0]    o_ram_region,
   output logic          o_rom_loaded,
   output logic          o_core_reset,
   output logic          o_dl_overflow,
   output logic [15:0]   o_dl_sum
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [2:0]    region;
      logic [1:0]    ds;
      logic [15:0]   din;
      logic [AW-1:0] addr;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   // Lowest region whose exclusive end lies above the byte address.
   function automatic logic [2:0] f_region(input logic [24:0] a);
      logic [2:0] r;
      r = 3'(NREG);
      for (int i = NREG - 1; i >= 0; i--) begin
         if (a < REG_END[i*25 +: 25]) r = 3'(i);
      end
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Pair buffer and packing
   // ------------------------------------------------------------------
   logic        r_buf_valid;
   logic [24:0] r_buf_addr;
   logic [7:0]  r_buf_data;

   logic        w_match;
   logic        w_push_a;     // flush of the pair buffer as an even-only word
   logic        w_push_b;     // word built from the current odd byte
   logic        w_buf_load;
   logic        w_buf_clr;
   entry_t      w_word_a;
   entry_t      w_word_b;

   assign w_match = r_buf_valid && (r_buf_addr[24:1] == i_ioctl_addr[24:1]);

   always_comb begin
      w_push_a        = 1'b0;
      w_push_b        = 1'b0;
      w_buf_load      = 1'b0;
      w_buf_clr       = 1'b0;
      w_word_a.region = f_region(r_buf_addr);
      w_word_a.ds     = 2'b01;
      w_word_a.din    = {8'h00, r_buf_data};
      w_word_a.addr   = r_buf_addr[AW:1];
      w_word_b.region = f_region(i_ioctl_addr);
      w_word_b.ds     = 2'b10;
      w_word_b.din    = {i_ioctl_dout, 8'h00};
      w_word_b.addr   = i_ioctl_addr[AW:1];
      if (!i_ioctl_downl) begin
         // Download over: a lone even byte still waiting is written out.
         w_push_a  = r_buf_valid;
         w_buf_clr = 1'b1;
      end else if (i_ioctl_wr) begin
         if (!i_ioctl_addr[0]) begin
            w_push_a   = r_buf_valid;
            w_buf_load = 1'b1;
         end else if (w_match) begin
            w_push_b        = 1'b1;
            w_buf_clr       = 1'b1;
            w_word_b.region = f_region(r_buf_addr);
            w_word_b.ds     = 2'b11;
            w_word_b.din    = {i_ioctl_dout, r_buf_data};
         end else begin
            w_push_a  = r_buf_valid;
            w_push_b  = 1'b1;
            w_buf_clr = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_buf_valid <= 1'b0;
         r_buf_addr  <= '0;
         r_buf_data  <= '0;
      end else if (w_buf_load) begin
         r_buf_valid <= 1'b1;
         r_buf_addr  <= i_ioctl_addr;
         r_buf_data  <= i_ioctl_dout;
      end else if (w_buf_clr) begin
         r_buf_valid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Word FIFO, up to two pushes per cycle
   // ------------------------------------------------------------------
   entry_t          r_mem [FIFO_DEPTH];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;

   logic            w_load;
   logic            w_toggle;
   logic            w_pop;
   logic [CW-1:0]   w_free;
   logic            w_wr0;
   logic            w_wr1;
   logic            w_lost;
   logic [1:0]      w_nacc;
   entry_t          w_word0;

   assign w_pop   = w_load;
   // Slots available this cycle, counting the one a concurrent pop releases.
   assign w_free  = CW'(FIFO_DEPTH) - r_count + CW'(w_pop);
   assign w_word0 = w_push_a ? w_word_a : w_word_b;
   assign w_wr0   = (w_push_a | w_push_b) & (w_free != '0);
   assign w_wr1   = w_push_a & w_push_b & (w_free >= CW'(2));
   assign w_lost  = ((w_push_a | w_push_b) & ~w_wr0) |
                    (w_push_a & w_push_b & ~w_wr1);
   assign w_nacc  = {1'b0, w_wr0} + {1'b0, w_wr1};

   always_ff @(posedge i_clk_sys) begin
      if (w_wr0) r_mem[r_wptr]        <= w_word0;
      if (w_wr1) r_mem[r_wptr + 1'b1] <= w_word_b;
   end

   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + PW'(w_nacc);
         r_rptr  <= r_rptr + PW'(w_pop);
         r_count <= r_count + CW'(w_nacc) - CW'(w_pop);
      end
   end

   // ------------------------------------------------------------------
   // Issue FSM
   // ------------------------------------------------------------------
   state_t r_state;
   state_t w_state_nxt;
   logic   r_ram_req;
   entry_t r_out;

   always_ff @(posedge i_clk_sys) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_toggle    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((r_count != '0) && (r_ram_req == i_ram_ack)) begin
               w_load      = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            w_toggle    = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (i_ram_ack == r_ram_req) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         // Follow the port's ack so the first request after reset is clean
         // even when the SDRAM side was not reset with us.
         r_ram_req <= i_ram_ack;
         r_out     <= '0;
      end else begin
         if (w_load)   r_out     <= r_mem[r_rptr];
         if (w_toggle) r_ram_req <= ~r_ram_req;
      end
   end

   // ------------------------------------------------------------------
   // Status
   // ------------------------------------------------------------------
   logic w_busy;
   logic r_busy_d;
   logic r_seen_dl;
   logic r_rom_loaded;
   logic r_overflow;

   // The state term covers the cycle between popping the last word and
   // toggling ram_req, when FIFO, buffer and handshake all look idle.
   assign w_busy = i_ioctl_downl | (r_count != '0) | r_buf_valid |
                   (r_ram_req != i_ram_ack) | (r_state != S_IDLE);

   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_busy_d     <= 1'b0;
         r_seen_dl    <= 1'b0;
         r_rom_loaded <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_busy_d <= w_busy;
         if (i_ioctl_downl)                      r_seen_dl    <= 1'b1;
         if (r_seen_dl && r_busy_d && !w_busy)   r_rom_loaded <= 1'b1;
         if (w_lost)                             r_overflow   <= 1'b1;
      end
   end

`ifdef DL_CHECKSUM_EN
   logic        r_downl_d;
   logic [15:0] r_sum;
   logic        w_acc;

   assign w_acc = i_ioctl_downl & i_ioctl_wr;

   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_downl_d <= 1'b0;
         r_sum     <= '0;
      end else begin
         r_downl_d <= i_ioctl_downl;
         if (i_ioctl_downl && !r_downl_d)
            r_sum <= w_acc ? {8'h00, i_ioctl_dout} : 16'h0000;
         else if (w_acc)
            r_sum <= r_sum + {8'h00, i_ioctl_dout};
      end
   end

   assign o_dl_sum = r_sum;
`else
   assign o_dl_sum = 16'h0000;
`endif

   assign o_ram_addr    = r_out.addr;
   assign o_ram_din     = r_out.din;
   assign o_ram_ds      = r_out.ds;
   assign o_ram_region  = r_out.region;
   assign o_ram_req     = r_ram_req;
   assign o_ram_we      = w_busy & ~i_reset;
   assign o_rom_loaded  = r_rom_loaded;
   assign o_core_reset  = i_reset | i_user_reset | ~r_rom_loaded | w_busy;
   assign o_dl_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rom_dl_sdram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_rom_dl_sdram_ctrl
//  Purpose  : Self-checking bench for rom_dl_sdram_ctrl. A toggle-handshake
//             SDRAM responder records every issued word; a byte-level
//             reference model predicts the words and checksum.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rom_dl_sdram_ctrl;

   localparam int AW   = 22;
   localparam int NREG = 4;
   localparam int FD   = 4;
   localparam logic [NREG*25-1:0] REG_END = {25'h0040000, 25'h0010000,
                                             25'h0008000, 25'h0004000};

   typedef logic [42:0] word_t;   // {addr[21:0], din[15:0], ds[1:0], region[2:0]}

   logic          clk = 1'b0;
   logic          reset, downl, wr, user_reset, ram_ack;
   logic [24:0]   addr;
   logic [7:0]    dout;
   logic [AW-1:0] o_ram_addr;
   logic [15:0]   o_ram_din, o_dl_sum;
   logic [1:0]    o_ram_ds;
   logic [2:0]    o_ram_region;
   logic          o_ram_req, o_ram_we, o_rom_loaded, o_core_reset, o_dl_overflow;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rom_dl_sdram_ctrl #(.AW(AW), .NREG(NREG), .REG_END(REG_END), .FIFO_DEPTH(FD)) dut (
      .i_clk_sys(clk), .i_reset(reset), .i_ioctl_downl(downl), .i_ioctl_wr(wr),
      .i_ioctl_addr(addr), .i_ioctl_dout(dout), .i_user_reset(user_reset),
      .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .o_ram_ds(o_ram_ds),
      .o_ram_req(o_ram_req), .i_ram_ack(ram_ack), .o_ram_we(o_ram_we),
      .o_ram_region(o_ram_region), .o_rom_loaded(o_rom_loaded),
      .o_core_reset(o_core_reset), .o_dl_overflow(o_dl_overflow), .o_dl_sum(o_dl_sum)
   );

   // ---------------- SDRAM responder ----------------
   int    ack_delay = 4;
   bit    pend = 0;
   int    cnt  = 0;
   word_t got_q[$];

   initial begin
      ram_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!pend && (o_ram_req !== ram_ack)) begin
            got_q.push_back({o_ram_addr, o_ram_din, o_ram_ds, o_ram_region});
            pend = 1;
            cnt  = ack_delay;
         end else if (pend) begin
            if (cnt == 0) begin
               ram_ack = o_ram_req;
               pend    = 0;
            end else begin
               cnt--;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   logic [24:0] bq_a[$];
   logic [7:0]  bq_d[$];
   word_t       exp_q[$];

   function automatic logic [2:0] tb_region(input logic [24:0] a);
      for (int i = 0; i < NREG; i++)
         if (a < REG_END[i*25 +: 25]) return 3'(i);
      return 3'(NREG);
   endfunction

   function automatic word_t mkw(input logic [24:0] ba, input logic [15:0] din,
                                 input logic [1:0] ds, input logic [24:0] ra);
      return {ba[22:1], din, ds, tb_region(ra)};
   endfunction

   task automatic model_words();
      bit          pv;
      logic [24:0] pa;
      logic [7:0]  pd;
      pv = 0; pa = '0; pd = '0;
      exp_q.delete();
      foreach (bq_a[i]) begin
         if (!bq_a[i][0]) begin
            if (pv) exp_q.push_back(mkw(pa, {8'h00, pd}, 2'b01, pa));
            pv = 1; pa = bq_a[i]; pd = bq_d[i];
         end else if (pv && (pa >> 1) == (bq_a[i] >> 1)) begin
            exp_q.push_back(mkw(pa, {bq_d[i], pd}, 2'b11, pa));
            pv = 0;
         end else begin
            if (pv) exp_q.push_back(mkw(pa, {8'h00, pd}, 2'b01, pa));
            exp_q.push_back(mkw(bq_a[i], {bq_d[i], 8'h00}, 2'b10, bq_a[i]));
            pv = 0;
         end
      end
      if (pv) exp_q.push_back(mkw(pa, {8'h00, pd}, 2'b01, pa));
   endtask

   function automatic logic [15:0] model_sum();
      logic [15:0] s;
      s = 16'h0000;
`ifdef DL_CHECKSUM_EN
      foreach (bq_d[i]) s = s + {8'h00, bq_d[i]};
`endif
      return s;
   endfunction

   // ---------------- drive helpers ----------------
   task automatic start_dl();
      @(negedge clk);
      bq_a.delete(); bq_d.delete(); got_q.delete();
      downl = 1'b1;
   endtask

   task automatic send(input logic [24:0] a, input logic [7:0] d, input int gap);
      @(negedge clk);
      wr = 1'b1; addr = a; dout = d;
      if (downl) begin bq_a.push_back(a); bq_d.push_back(d); end
      @(negedge clk);
      wr = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic end_dl();
      @(negedge clk);
      downl = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int k;
      k = 0;
      while ((o_ram_we !== 1'b0 || pend) && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (k >= budget) begin
         n_fail++;
         $display("FAIL %s drain timeout: still busy after %0d cycles", nm, k);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_words(input string nm);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL %s word count: got %0d expected %0d", nm, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s word %0d: got %h expected %h", nm, i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic check_bit(input string nm, input logic got, input logic expv);
      n_cmp++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, got, expv);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_bit("reset ram_we", o_ram_we, 1'b0);
      check_bit("reset core_reset", o_core_reset, 1'b1);
      check_bit("reset rom_loaded", o_rom_loaded, 1'b0);
      check_bit("reset overflow", o_dl_overflow, 1'b0);
      check_bit("reset req==ack", o_ram_req, ram_ack);
      n_cmp++;
      if (o_dl_sum !== 16'h0 || o_ram_ds !== 2'b00) begin
         n_fail++;
         $display("FAIL reset sum/ds: got %h/%b expected 0000/00", o_dl_sum, o_ram_ds);
      end
      reset = 1'b0;
      @(negedge clk);
      check_bit("post-reset core_reset", o_core_reset, 1'b1);
   endtask

   task automatic test_single_byte();
      int k;
      ack_delay = 4;
      start_dl();
      send(25'h10, 8'hAB, 2);
      end_dl();
      k = 0;
      while (got_q.size() == 0 && k < 30) begin @(negedge clk); k++; end
      check_bit("single in-flight rom_loaded", o_rom_loaded, 1'b0);
      check_bit("single in-flight core_reset", o_core_reset, 1'b1);
      wait_idle(100, "single");
      model_words();
      check_words("single");
      check_bit("single rom_loaded", o_rom_loaded, 1'b1);
      check_bit("single core_reset", o_core_reset, 1'b0);
   endtask

   task automatic test_pair();
      int   k;
      logic r0;
      ack_delay = 4;
      start_dl();
      @(negedge clk);
      check_bit("pair busy core_reset", o_core_reset, 1'b1);
      send(25'h0, 8'h11, 2);
      @(negedge clk);
      wr = 1'b1; addr = 25'h1; dout = 8'h22;
      bq_a.push_back(25'h1); bq_d.push_back(8'h22);
      r0 = o_ram_req;
      k  = 0;
      do begin
         @(posedge clk); #1;
         wr = 1'b0;
         k++;
      end while (o_ram_req === r0 && k < 10);
      n_cmp++;
      if (k != 3) begin
         n_fail++;
         $display("FAIL pair latency: req toggled after %0d edges expected 3", k);
      end
      end_dl();
      wait_idle(100, "pair");
      model_words();
      check_words("pair");
      check_bit("pair rom_loaded", o_rom_loaded, 1'b1);
      check_bit("pair core_reset", o_core_reset, 1'b0);
      user_reset = 1'b1;
      @(negedge clk);
      check_bit("user_reset core_reset", o_core_reset, 1'b1);
      user_reset = 1'b0;
   endtask

   task automatic test_regions();
      ack_delay = 2;
      start_dl();
      send(25'h3FFE, 8'h01, 3);  send(25'h3FFF, 8'h02, 3);
      send(25'h4000, 8'h03, 3);  send(25'h4001, 8'h04, 3);
      send(25'h40002, 8'h05, 3); send(25'h40003, 8'h06, 3);
      end_dl();
      wait_idle(200, "regions");
      model_words();
      check_words("regions");
   endtask

   task automatic test_overflow();
      ack_delay = 100;
      start_dl();
      for (int i = 0; i < 12; i++) send(25'h100 + 25'(i), 8'(8'h30 + i), 1);
      end_dl();
      wait_idle(1500, "overflow");
      model_words();
      while (exp_q.size() > FD + 1) void'(exp_q.pop_back());
      check_words("overflow");
      check_bit("overflow flag", o_dl_overflow, 1'b1);
   endtask

   task automatic test_reset_mid();
      int n0;
      if (ram_ack !== 1'b1) begin
         ack_delay = 2;
         start_dl();
         send(25'h20, 8'h5A, 2);
         end_dl();
         wait_idle(100, "reset_mid prep");
      end
      ack_delay = 20;
      start_dl();
      for (int i = 0; i < 6; i++) send(25'h200 + 25'(i), 8'($urandom), 1);
      @(negedge clk);
      reset = 1'b1; downl = 1'b0;
      n0 = got_q.size();
      @(negedge clk);
      check_bit("reset_mid req resync", o_ram_req, 1'b1);
      check_bit("reset_mid ram_we", o_ram_we, 1'b0);
      check_bit("reset_mid overflow", o_dl_overflow, 1'b0);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check_bit("reset_mid req stable", o_ram_req, 1'b1);
      check_bit("reset_mid idle ram_we", o_ram_we, 1'b0);
      check_bit("reset_mid core_reset", o_core_reset, 1'b1);
      n_cmp++;
      if (got_q.size() != n0 || n0 != 1) begin
         n_fail++;
         $display("FAIL reset_mid writes: got %0d (at reset %0d) expected 1", got_q.size(), n0);
      end
   endtask

   task automatic test_checksum();
      ack_delay = 1;
      start_dl();
      send(25'h0, 8'hFF, 3); send(25'h1, 8'hFF, 3); send(25'h2, 8'h02, 3);
      end_dl();
      wait_idle(200, "checksum");
      n_cmp++;
`ifdef DL_CHECKSUM_EN
      if (o_dl_sum !== 16'h0200) begin
         n_fail++;
         $display("FAIL checksum FF,FF,02: got %h expected 0200", o_dl_sum);
      end
`else
      if (o_dl_sum !== 16'h0000) begin
         n_fail++;
         $display("FAIL checksum disabled: got %h expected 0000", o_dl_sum);
      end
`endif
      model_words();
      check_words("checksum");
   endtask

   task automatic test_ignore_idle();
      @(negedge clk);
      got_q.delete();
      send(25'h40, 8'h55, 2);
      send(25'h41, 8'h66, 2);
      repeat (10) @(negedge clk);
      n_cmp++;
      if (got_q.size() != 0 || o_ram_we !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore idle: writes %0d ram_we %b expected 0/0", got_q.size(), o_ram_we);
      end
   endtask

   task automatic test_random();
      logic [24:0] a;
      int          n;
      for (int t = 0; t < 6; t++) begin
         ack_delay = $urandom_range(0, 5);
         start_dl();
         n = $urandom_range(1, 10);
         a = 25'($urandom_range(0, 32'h4FFFF));
         for (int i = 0; i < n; i++) begin
            send(a, 8'($urandom), $urandom_range(12, 16));
            a = a + 25'($urandom_range(1, 3));
         end
         end_dl();
         wait_idle(400, "random");
         model_words();
         check_words("random");
         n_cmp++;
         if (o_dl_sum !== model_sum()) begin
            n_fail++;
            $display("FAIL random dl_sum: got %h expected %h", o_dl_sum, model_sum());
         end
         check_bit("random rom_loaded", o_rom_loaded, 1'b1);
         check_bit("random core_reset", o_core_reset, 1'b0);
         check_bit("random overflow", o_dl_overflow, 1'b0);
      end
   endtask

   initial begin
      reset = 1'b1; downl = 1'b0; wr = 1'b0; addr = '0; dout = '0; user_reset = 1'b0;
      test_reset();
      test_single_byte();
      test_pair();
      test_regions();
      test_overflow();
      test_reset_mid();
      test_random();
      test_checksum();
      test_ignore_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
